vmicro16_apb_rr_intercon: RTL and testbench

Parametrised multi-master/multi-slave APB interconnect, successor to the single-decode cluster interconnect. It sits between N cluster APB masters and M main-bus peripherals. It grants masters by fair round-robin, decodes the slave from an address field, and completes each transfer through a registered setup/access sequence. Unmapped addresses and hung slaves get an error response (PSLVERR) instead of a bus lock-up.

---
 rtl/vmicro16_apb_rr_intercon.sv | 257 +++++++++++++++++++++++++
 tb/tb_vmicro16_apb_rr_intercon.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vmicro16_apb_rr_intercon.sv
// Purpose     : N-master / M-slave APB interconnect. It grants masters round-robin, decodes the slave
//               from a PADDR bit field, and answers PSLVERR for unmapped addresses or hung slaves.
// Latency     : a request to a zero-wait slave gets S_PREADY in cycle 4, plus 1 cycle per wait state.
//               An unmapped address gets S_PREADY in cycle 2.
// Backpressure: one transfer is in flight at a time. Masters that are not granted keep S_PSELx high
//               and see S_PREADY=0 until they win.
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   S_P*                    packed per-master APB slave ports (master i at slice i)
//   M_P*                    shared downstream APB master port; M_PSELx is one-hot per slave
//   GRANT                   one-hot owner of the bus; 0 while idle
module vmicro16_apb_rr_intercon #(
   parameter int BUS_WIDTH  = 16,
   parameter int DATA_WIDTH = 16,
   parameter int MASTERS    = 4,
   parameter int SLAVES     = 2,
   parameter int ADDR_MSB   = 12,
   parameter int ADDR_LSB   = 12,
   parameter int TIMEOUT    = 255,
   parameter logic [DATA_WIDTH-1:0] ERR_DATA = 16'hDEAD
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [MASTERS*BUS_WIDTH-1:0]  S_PADDR,
   input  logic [MASTERS-1:0]            S_PWRITE,
   input  logic [MASTERS-1:0]            S_PSELx,
   input  logic [MASTERS-1:0]            S_PENABLE,
   input  logic [MASTERS*DATA_WIDTH-1:0] S_PWDATA,
   output logic [MASTERS*DATA_WIDTH-1:0] S_PRDATA,
   output logic [MASTERS-1:0]            S_PREADY,
   output logic [MASTERS-1:0]            S_PSLVERR,
   output logic [BUS_WIDTH-1:0]          M_PADDR,
   output logic                          M_PWRITE,
   output logic [SLAVES-1:0]             M_PSELx,
   output logic                          M_PENABLE,
   output logic [DATA_WIDTH-1:0]         M_PWDATA,
   input  logic [SLAVES*DATA_WIDTH-1:0]  M_PRDATA,
   input  logic [SLAVES-1:0]             M_PREADY,
   output logic [MASTERS-1:0]            GRANT
);

   localparam int MIDX_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;
   localparam int SIDX_W = ADDR_MSB - ADDR_LSB + 1;
   localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

   state_t                        state_q, state_d;
   logic [MIDX_W-1:0]             ptr_q, ptr_d;
   logic [MIDX_W-1:0]             gidx_q, gidx_d;
   logic [SIDX_W-1:0]             sidx_q, sidx_d;
   logic [BUS_WIDTH-1:0]          addr_q, addr_d;
   logic                          write_q, write_d;
   logic [DATA_WIDTH-1:0]         wdata_q, wdata_d;
   logic [TO_W-1:0]               cnt_q, cnt_d;
   logic [SLAVES-1:0]             m_psel_q, m_psel_d;
   logic                          m_penable_q, m_penable_d;
   logic [MASTERS-1:0]            s_pready_q, s_pready_d;
   logic [MASTERS-1:0]            s_pslverr_q, s_pslverr_d;
   logic [MASTERS-1:0]            grant_q, grant_d;
   logic [MASTERS*DATA_WIDTH-1:0] s_prdata_q, s_prdata_d;

   // PENABLE from the masters carries no information the FSM needs.
   logic unused_s_penable;
   assign unused_s_penable = ^S_PENABLE;

   // Round-robin pick. The first requester above ptr wins. If there is none, the lowest
   // requester at or below ptr wins.
   logic              hi_found, lo_found, req_vld;
   logic [MIDX_W-1:0] hi_idx, lo_idx, req_idx;
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int j = MASTERS - 1; j >= 0; j--) begin
         if (S_PSELx[j]) begin
            if (j > int'(ptr_q)) begin
               hi_found = 1'b1;
               hi_idx   = MIDX_W'(j);
            end else begin
               lo_found = 1'b1;
               lo_idx   = MIDX_W'(j);
            end
         end
      end
      req_vld = hi_found | lo_found;
      req_idx = hi_found ? hi_idx : lo_idx;
   end

   // Request fields of the winning master.
   logic [BUS_WIDTH-1:0]  req_addr;
   logic                  req_write;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic [SIDX_W-1:0]     req_sidx;
   always_comb begin
      req_addr  = '0;
      req_write = 1'b0;
      req_wdata = '0;
      for (int m = 0; m < MASTERS; m++) begin
         if (m == int'(req_idx)) begin
            req_addr  = S_PADDR[m*BUS_WIDTH +: BUS_WIDTH];
            req_write = S_PWRITE[m];
            req_wdata = S_PWDATA[m*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      req_sidx = req_addr[ADDR_MSB:ADDR_LSB];
   end

   // Response of the addressed slave.
   logic                  sel_rdy;
   logic [DATA_WIDTH-1:0] sel_rdata;
   always_comb begin
      sel_rdy   = 1'b0;
      sel_rdata = '0;
      for (int s = 0; s < SLAVES; s++) begin
         if (s == int'(sidx_q)) begin
            sel_rdy   = M_PREADY[s];
            sel_rdata = M_PRDATA[s*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Next-state and registered-output logic.
   logic                  fin, fin_err;
   logic [DATA_WIDTH-1:0] fin_data;
   logic [MIDX_W-1:0]     fin_idx;
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gidx_d      = gidx_q;
      sidx_d      = sidx_q;
      addr_d      = addr_q;
      write_d     = write_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      m_psel_d    = m_psel_q;
      m_penable_d = m_penable_q;
      s_pready_d  = '0;
      s_pslverr_d = '0;
      grant_d     = grant_q;
      s_prdata_d  = s_prdata_q;
      fin         = 1'b0;
      fin_err     = 1'b0;
      fin_data    = '0;
      fin_idx     = gidx_q;

      case (state_q)
         IDLE: begin
            if (req_vld) begin
               gidx_d  = req_idx;
               addr_d  = req_addr;
               write_d = req_write;
               wdata_d = req_wdata;
               sidx_d  = req_sidx;
               for (int m = 0; m < MASTERS; m++) grant_d[m] = (m == int'(req_idx));
               if (int'(req_sidx) < SLAVES) begin
                  state_d = SETUP;
                  for (int s = 0; s < SLAVES; s++) m_psel_d[s] = (s == int'(req_sidx));
               end else begin
                  // Unmapped: answer the master directly, no downstream cycle.
                  state_d  = DONE;
                  fin      = 1'b1;
                  fin_err  = 1'b1;
                  fin_data = ERR_DATA;
                  fin_idx  = req_idx;
               end
            end
         end
         SETUP: begin
            state_d     = ACCESS;
            m_penable_d = 1'b1;
            cnt_d       = '0;
         end
         ACCESS: begin
            // Ready wins over a timeout that expires in the same cycle.
            if (sel_rdy) begin
               state_d     = DONE;
               m_psel_d    = '0;
               m_penable_d = 1'b0;
               fin         = 1'b1;
               fin_data    = sel_rdata;
            end else if (TIMEOUT != 0 && int'(cnt_q) + 1 >= TIMEOUT) begin
               state_d     = DONE;
               m_psel_d    = '0;
               m_penable_d = 1'b0;
               fin         = 1'b1;
               fin_err     = 1'b1;
               fin_data    = ERR_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            ptr_d   = gidx_q;
            grant_d = '0;
         end
         default: state_d = IDLE;
      endcase

      if (fin) begin
         for (int m = 0; m < MASTERS; m++) begin
            if (m == int'(fin_idx)) begin
               s_pready_d[m]                          = 1'b1;
               s_pslverr_d[m]                         = fin_err;
               s_prdata_d[m*DATA_WIDTH +: DATA_WIDTH] = fin_data;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= MIDX_W'(MASTERS - 1);
         gidx_q      <= '0;
         sidx_q      <= '0;
         addr_q      <= '0;
         write_q     <= 1'b0;
         wdata_q     <= '0;
         cnt_q       <= '0;
         m_psel_q    <= '0;
         m_penable_q <= 1'b0;
         s_pready_q  <= '0;
         s_pslverr_q <= '0;
         grant_q     <= '0;
         s_prdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gidx_q      <= gidx_d;
         sidx_q      <= sidx_d;
         addr_q      <= addr_d;
         write_q     <= write_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         m_psel_q    <= m_psel_d;
         m_penable_q <= m_penable_d;
         s_pready_q  <= s_pready_d;
         s_pslverr_q <= s_pslverr_d;
         grant_q     <= grant_d;
         s_prdata_q  <= s_prdata_d;
      end
   end

   assign M_PADDR   = addr_q;
   assign M_PWRITE  = write_q;
   assign M_PWDATA  = wdata_q;
   assign M_PSELx   = m_psel_q;
   assign M_PENABLE = m_penable_q;
   assign S_PREADY  = s_pready_q;
   assign S_PSLVERR = s_pslverr_q;
   assign S_PRDATA  = s_prdata_q;
   assign GRANT     = grant_q;

endmodule

// File: tb/tb_vmicro16_apb_rr_intercon.sv
module tb_vmicro16_apb_rr_intercon;

   localparam int BW = 16;
   localparam int DW = 16;
   localparam int NM = 4;
   localparam int NS = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [NM*BW-1:0]  S_PADDR;
   logic [NM-1:0]     S_PWRITE, S_PSELx, S_PENABLE;
   logic [NM*DW-1:0]  S_PWDATA, S_PRDATA;
   logic [NM-1:0]     S_PREADY, S_PSLVERR, GRANT;
   logic [BW-1:0]     M_PADDR;
   logic              M_PWRITE, M_PENABLE;
   logic [NS-1:0]     M_PSELx, M_PREADY;
   logic [DW-1:0]     M_PWDATA;
   logic [NS*DW-1:0]  M_PRDATA;

   int errors = 0;
   int checks = 0;

   vmicro16_apb_rr_intercon #(
      .BUS_WIDTH(BW), .DATA_WIDTH(DW), .MASTERS(NM), .SLAVES(NS),
      .ADDR_MSB(13), .ADDR_LSB(12), .TIMEOUT(8), .ERR_DATA(16'hDEAD)
   ) dut (
      .clk(clk), .reset(reset),
      .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE), .S_PSELx(S_PSELx), .S_PENABLE(S_PENABLE),
      .S_PWDATA(S_PWDATA), .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY), .S_PSLVERR(S_PSLVERR),
      .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE), .M_PSELx(M_PSELx), .M_PENABLE(M_PENABLE),
      .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY), .GRANT(GRANT)
   );

   always #5 clk = ~clk;

   // Behavioural slaves: a 16-word memory each and a programmable number of wait states.
   logic [DW-1:0] mem [0:1][0:15];
   int            wcnt [2];
   int            wcfg [2];

   always_comb begin
      for (int s = 0; s < NS; s++) begin
         M_PREADY[s]           = M_PSELx[s] && M_PENABLE && (wcnt[s] >= wcfg[s]);
         M_PRDATA[s*DW +: DW]  = mem[s][M_PADDR[3:0]];
      end
   end

   always @(posedge clk) begin
      for (int s = 0; s < NS; s++) begin
         if (M_PSELx[s] && M_PENABLE) begin
            if (M_PREADY[s]) begin
               if (M_PWRITE) mem[s][M_PADDR[3:0]] <= M_PWDATA;
               wcnt[s] <= 0;
            end else begin
               wcnt[s] <= wcnt[s] + 1;
            end
         end else begin
            wcnt[s] <= 0;
         end
      end
   end

   // Bus invariant: at most one slave selected; enable only alongside a select.
   always @(negedge clk) begin
      checks++;
      if ($countones(M_PSELx) > 1 || (M_PENABLE && M_PSELx == '0)) begin
         errors++;
         $display("FAIL bus_invariant at %0t: M_PSELx=%b M_PENABLE=%b", $time, M_PSELx, M_PENABLE);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int m, input bit wr, input logic [15:0] a, input logic [15:0] d);
      S_PADDR[m*BW +: BW]  = a;
      S_PWRITE[m]          = wr;
      S_PWDATA[m*DW +: DW] = d;
   endtask

   // Raise a request in cycle 1 and count cycles until S_PREADY. Returns -1 cycles if no response.
   task automatic do_xfer(input int m, input bit wr, input logic [15:0] a, input logic [15:0] d,
                          output int cyc, output bit err, output logic [15:0] rd,
                          output logic [1:0] psel_seen, output int pen, output logic [3:0] g2);
      set_req(m, wr, a, d);
      S_PSELx[m] = 1'b1;
      cyc = -1; err = 1'b0; rd = '0; psel_seen = '0; pen = 0; g2 = '0;
      for (int c = 2; c <= 40; c++) begin
         tick();
         psel_seen = psel_seen | M_PSELx;
         if (M_PENABLE) pen++;
         if (c == 2) g2 = GRANT;
         if (S_PREADY[m]) begin
            cyc = c;
            err = S_PSLVERR[m];
            rd  = S_PRDATA[m*DW +: DW];
            break;
         end
      end
      S_PSELx[m] = 1'b0;
      tick();
   endtask

   typedef struct {
      int          m;
      bit          wr;
      logic [15:0] addr;
      logic [15:0] wd;
      int          wt;
      int          cyc;
      bit          err;
      bit          chk_rd;
      logic [15:0] rd;
      logic [1:0]  psel;
      int          pen;
   } vec_t;

   vec_t vec [9];

   initial begin
      int          cyc, pen;
      bit          err;
      logic [15:0] rd;
      logic [1:0]  ps;
      logic [3:0]  g2, req;
      int          order[$];
      int          done_cyc[$];
      int          rq_cnt;

      //          m  wr    addr      wdata     wt cyc err chk rdata     psel   pen
      vec[0] = '{0, 1'b1, 16'h1010, 16'h1234, 0,  4, 0,  0, 16'h0000, 2'b10, 1};
      vec[1] = '{0, 1'b0, 16'h1010, 16'h0000, 0,  4, 0,  1, 16'h1234, 2'b10, 1};
      vec[2] = '{2, 1'b0, 16'h2000, 16'h0000, 0,  2, 1,  1, 16'hDEAD, 2'b00, 0};
      vec[3] = '{1, 1'b1, 16'h0004, 16'hABCD, 3,  7, 0,  0, 16'h0000, 2'b01, 4};
      vec[4] = '{3, 1'b0, 16'h0004, 16'h0000, 3,  7, 0,  1, 16'hABCD, 2'b01, 4};
      vec[5] = '{1, 1'b0, 16'h0004, 16'h0000, 99, 11, 1, 1, 16'hDEAD, 2'b01, 8};
      vec[6] = '{1, 1'b0, 16'h0004, 16'h0000, 7,  11, 0, 1, 16'hABCD, 2'b01, 8};
      vec[7] = '{3, 1'b1, 16'h3000, 16'h5555, 0,  2, 1,  1, 16'hDEAD, 2'b00, 0};
      vec[8] = '{0, 1'b0, 16'h1010, 16'h0000, 0,  4, 0,  1, 16'h1234, 2'b10, 1};

      reset = 1'b1;
      S_PADDR = '0; S_PWRITE = '0; S_PSELx = '0; S_PENABLE = '0; S_PWDATA = '0;
      wcfg[0] = 0; wcfg[1] = 0;
      repeat (3) tick();
      reset = 1'b0;

      // Reset state.
      chk("rst_grant", 32'(GRANT), 32'h0);
      chk("rst_pready", 32'(S_PREADY), 32'h0);
      chk("rst_pslverr", 32'(S_PSLVERR), 32'h0);
      chk("rst_mpsel", 32'(M_PSELx), 32'h0);
      chk("rst_penable", 32'(M_PENABLE), 32'h0);
      chk("rst_prdata", 32'(|S_PRDATA), 32'h0);

      // Round-robin fairness: all masters request; master 0 re-requests after its first grant.
      for (int m = 0; m < NM; m++) set_req(m, 1'b0, 16'h1010, 16'h0);
      req = 4'hF;
      rq_cnt = 0;
      S_PSELx = req;
      for (int c = 1; c <= 100 && order.size() < 5; c++) begin
         tick();
         if (rq_cnt > 0) begin
            rq_cnt--;
            if (rq_cnt == 0) req[0] = 1'b1;
         end
         for (int g = 0; g < NM; g++) begin
            if (S_PREADY[g]) begin
               order.push_back(g);
               done_cyc.push_back(c);
               req[g] = 1'b0;
               if (order.size() == 1) rq_cnt = 2;
            end
         end
         S_PSELx = req;
      end
      S_PSELx = '0;
      tick();
      begin
         int exp_order [5] = '{0, 1, 2, 3, 0};
         for (int i = 0; i < 5; i++)
            chk($sformatf("rr_order%0d", i), (order.size() > i) ? order[i] : -1, exp_order[i]);
      end
      chk("rr_gap", (done_cyc.size() > 1) ? done_cyc[1] - done_cyc[0] : -1, 4);

      // Directed single transfers.
      for (int i = 0; i < 9; i++) begin
         wcfg[0] = vec[i].wt;
         wcfg[1] = vec[i].wt;
         do_xfer(vec[i].m, vec[i].wr, vec[i].addr, vec[i].wd, cyc, err, rd, ps, pen, g2);
         chk($sformatf("v%0d_cycles", i), cyc, vec[i].cyc);
         chk($sformatf("v%0d_pslverr", i), 32'(err), 32'(vec[i].err));
         if (vec[i].chk_rd) chk($sformatf("v%0d_prdata", i), 32'(rd), 32'(vec[i].rd));
         chk($sformatf("v%0d_mpsel", i), 32'(ps), 32'(vec[i].psel));
         chk($sformatf("v%0d_penable_cycles", i), pen, vec[i].pen);
         chk($sformatf("v%0d_grant", i), 32'(g2), 32'(1) << vec[i].m);
         chk($sformatf("v%0d_grant_idle", i), 32'(GRANT), 32'h0);
      end

      // Read data is held per master until that master completes again.
      chk("hold_prdata_m1", 32'(S_PRDATA[1*DW +: DW]), 32'hABCD);
      chk("hold_prdata_m2", 32'(S_PRDATA[2*DW +: DW]), 32'hDEAD);
      chk("hold_prdata_m3", 32'(S_PRDATA[3*DW +: DW]), 32'hDEAD);

      // Reset during ACCESS, then check that master 0 again has first priority.
      wcfg[1] = 99;
      set_req(2, 1'b0, 16'h1010, 16'h0);
      S_PSELx[2] = 1'b1;
      for (int c = 0; c < 10 && !M_PENABLE; c++) tick();
      chk("mid_in_access", 32'(M_PENABLE), 32'h1);
      reset = 1'b1;
      tick();
      chk("mid_rst_mpsel", 32'(M_PSELx), 32'h0);
      chk("mid_rst_penable", 32'(M_PENABLE), 32'h0);
      chk("mid_rst_grant", 32'(GRANT), 32'h0);
      chk("mid_rst_pready", 32'(S_PREADY), 32'h0);
      chk("mid_rst_prdata", 32'(|S_PRDATA), 32'h0);
      reset = 1'b0;
      wcfg[1] = 0;
      set_req(0, 1'b0, 16'h1010, 16'h0);
      S_PSELx = 4'b0101;
      tick();
      chk("post_rst_grant", 32'(GRANT), 32'h1);
      for (int c = 0; c < 10 && !S_PREADY[0]; c++) tick();
      chk("post_rst_pready_m0", 32'(S_PREADY), 32'h1);
      chk("post_rst_prdata_m0", 32'(S_PRDATA[0 +: DW]), 32'h1234);
      S_PSELx = '0;
      repeat (2) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
